clk_div_multi: RTL and testbench

//  Multi-channel, run-time programmable clock divider / tick generator.

---
 rtl/clk_div_pkg.sv | 15 +
 rtl/clk_div_if.sv | 27 ++
 rtl/clk_div_chan.sv | 89 ++++++++
 rtl/clk_div_multi.sv | 41 ++++
 tb/tb_clk_div_multi.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Latency: n/a (package only).
// Backpressure: n/a.
package clk_div_pkg;

  localparam int          CNT_W_DEFAULT    = 32;
  localparam int unsigned DEF_HALF_DEFAULT = 1;

  // Half-period count for a wanted output frequency; 0 when f_out is 0.
  function automatic longint unsigned half_from_hz(input longint unsigned f_clk,
                                                   input longint unsigned f_out);
    return (f_out == 64'd0) ? 64'd0 : f_clk / (64'd2 * f_out);
  endfunction

endpackage

// File: rtl/clk_div_if.sv
// Control and status bundle of the multi-channel divider.
// Latency: n/a (wires only).
// Backpressure: none; loads are single-cycle pulses, outputs are registered enables.
interface clk_div_if
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEFAULT
);
  logic [NUM_CH-1:0]       en;
  logic                    sync_clr;
  logic [NUM_CH-1:0]       div_load;
  logic [NUM_CH*CNT_W-1:0] div_val;
  logic [NUM_CH-1:0]       clk_div;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       pending;

  modport master (
    output en, sync_clr, div_load, div_val,
    input  clk_div, tick, pending
  );

  modport slave (
    input  en, sync_clr, div_load, div_val,
    output clk_div, tick, pending
  );
endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: square wave of period 2*N plus a tick on each toggle.
// Latency: first toggle N enabled cycles after reset/sync_clr; outputs registered.
// Backpressure: none; en=0 freezes the phase, new N waits for the next half-period boundary.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int          CNT_W    = CNT_W_DEFAULT,
  parameter int unsigned DEF_HALF = DEF_HALF_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_val,
  output logic             clk_div,
  output logic             tick,
  output logic             pending
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] shadow;
  logic             off;
  logic             wrap;

  // A value loaded while frozen may be shorter than the frozen count, so
  // wrap on ">=" to end that half-period at once instead of rolling over.
  assign off  = (half == '0);
  assign wrap = (count >= half - CNT_W'(1));

  // Phase counter, output toggle and shadow-to-active handover of N.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      half    <= CNT_W'(DEF_HALF);
      shadow  <= '0;
      pending <= 1'b0;
      clk_div <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (div_load) begin
        shadow <= div_val;
      end

      if (sync_clr) begin
        // Phase-align: a same-cycle load beats an older pending value.
        count   <= '0;
        clk_div <= 1'b0;
        tick    <= 1'b0;
        pending <= 1'b0;
        if (div_load) begin
          half <= div_val;
        end else if (pending) begin
          half <= shadow;
        end
      end else if (off || !en) begin
        // Nothing is in flight, so a pending value is taken on this edge.
        tick <= 1'b0;
        if (off) begin
          count   <= '0;
          clk_div <= 1'b0;
        end
        if (pending) begin
          half <= shadow;
        end
        pending <= div_load;
      end else if (wrap) begin
        // Half-period boundary: toggle and switch to the newest N.
        count   <= '0;
        clk_div <= ~clk_div;
        tick    <= 1'b1;
        pending <= 1'b0;
        if (div_load) begin
          half <= div_val;
        end else if (pending) begin
          half <= shadow;
        end
      end else begin
        count <= count + CNT_W'(1);
        tick  <= 1'b0;
        if (div_load) begin
          pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable divider: NUM_CH independent clk_div_chan instances.
// Latency: per channel, first toggle N enabled cycles after reset/sync_clr.
// Backpressure: none; sync_clr is shared, everything else is per channel.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int          NUM_CH   = 4,
  parameter int          CNT_W    = CNT_W_DEFAULT,
  parameter int unsigned DEF_HALF = DEF_HALF_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  clk_div_if.slave  bus
);

  logic [NUM_CH-1:0] clk_div_w;
  logic [NUM_CH-1:0] tick_w;
  logic [NUM_CH-1:0] pending_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    clk_div_chan #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .en       (bus.en[i]),
      .sync_clr (bus.sync_clr),
      .div_load (bus.div_load[i]),
      .div_val  (bus.div_val[i*CNT_W +: CNT_W]),
      .clk_div  (clk_div_w[i]),
      .tick     (tick_w[i]),
      .pending  (pending_w[i])
    );
  end

  assign bus.clk_div = clk_div_w;
  assign bus.tick    = tick_w;
  assign bus.pending = pending_w;

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed scenarios plus randomized runs against a countdown model.
// Latency: n/a.
// Backpressure: n/a.
module tb_clk_div_multi;
  import clk_div_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  clk_div_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  clk_div_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_HALF(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: remaining cycles until the next toggle, active N, queued N.
  int unsigned m_n    [NUM_CH];
  int unsigned m_q    [NUM_CH];
  int unsigned m_rem  [NUM_CH];
  bit          m_pend [NUM_CH];
  bit          m_out  [NUM_CH];
  bit          m_tk   [NUM_CH];

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_n[i] = 1; m_q[i] = 0; m_rem[i] = 1;
      m_pend[i] = 0; m_out[i] = 0; m_tk[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < NUM_CH; i++) begin
      bit          ld;
      bit          e;
      int unsigned v;
      int unsigned elapsed;
      ld = bus.div_load[i];
      e  = bus.en[i];
      v  = bus.div_val[i*CNT_W +: CNT_W];
      if (bus.sync_clr) begin
        if (ld) m_n[i] = v;
        else if (m_pend[i]) m_n[i] = m_q[i];
        m_rem[i] = m_n[i]; m_out[i] = 0; m_tk[i] = 0; m_pend[i] = 0;
      end else if (m_n[i] == 0) begin
        m_out[i] = 0; m_tk[i] = 0;
        if (m_pend[i]) m_n[i] = m_q[i];
        m_rem[i] = m_n[i];
        m_pend[i] = ld;
      end else if (!e) begin
        m_tk[i] = 0;
        if (m_pend[i]) begin
          elapsed = m_n[i] - m_rem[i];
          m_n[i] = m_q[i];
          if (m_n[i] == 0) m_rem[i] = 0;
          else if (elapsed + 1 >= m_n[i]) m_rem[i] = 1;
          else m_rem[i] = m_n[i] - elapsed;
        end
        m_pend[i] = ld;
      end else begin
        m_rem[i] = m_rem[i] - 1;
        if (m_rem[i] == 0) begin
          m_out[i] = !m_out[i]; m_tk[i] = 1;
          if (ld) m_n[i] = v;
          else if (m_pend[i]) m_n[i] = m_q[i];
          m_rem[i] = m_n[i]; m_pend[i] = 0;
        end else begin
          m_tk[i] = 0;
          if (ld) m_pend[i] = 1;
        end
      end
      if (ld) m_q[i] = v;
    end
  endtask

  function automatic logic [NUM_CH-1:0] exp_out();
    for (int i = 0; i < NUM_CH; i++) exp_out[i] = m_out[i];
  endfunction
  function automatic logic [NUM_CH-1:0] exp_tick();
    for (int i = 0; i < NUM_CH; i++) exp_tick[i] = m_tk[i];
  endfunction
  function automatic logic [NUM_CH-1:0] exp_pend();
    for (int i = 0; i < NUM_CH; i++) exp_pend[i] = m_pend[i];
  endfunction

  // One rising edge; the model sees the same inputs, then return at the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_val(input int ch, input int unsigned v);
    bus.div_val[ch*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.en = '0; bus.sync_clr = 1'b0; bus.div_load = '0; bus.div_val = '0;
    model_reset();
    #23;
    n_tests++;
    if (bus.clk_div !== 4'b0000) begin n_fail++; $display("FAIL reset_clk_div got=%b exp=0000", bus.clk_div); end
    n_tests++;
    if (bus.tick !== 4'b0000) begin n_fail++; $display("FAIL reset_tick got=%b exp=0000", bus.tick); end
    n_tests++;
    if (bus.pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending got=%b exp=0000", bus.pending); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_pkg_helper();
    n_tests++;
    if (half_from_hz(64'd50_000_000, 64'd1_000) !== 64'd25_000) begin
      n_fail++; $display("FAIL half_from_hz got=%0d exp=25000", half_from_hz(64'd50_000_000, 64'd1_000));
    end
  endtask

  task automatic test_div2();
    bus.en = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_tests++;
      if (bus.clk_div !== {3'b000, k[0]}) begin n_fail++; $display("FAIL div2_clk k=%0d got=%b exp=%b", k, bus.clk_div, {3'b000, k[0]}); end
      n_tests++;
      if (bus.tick !== 4'b0001) begin n_fail++; $display("FAIL div2_tick k=%0d got=%b exp=0001", k, bus.tick); end
    end
  endtask

  task automatic test_load_n3();
    bus.div_load = 4'b0010; set_val(1, 3);
    step();
    bus.div_load = '0;
    n_tests++;
    if (bus.pending[1] !== 1'b1) begin n_fail++; $display("FAIL n3_pending_set got=%b exp=1", bus.pending[1]); end
    step();
    n_tests++;
    if (bus.pending[1] !== 1'b0) begin n_fail++; $display("FAIL n3_pending_pulse got=%b exp=0", bus.pending[1]); end
    bus.en = 4'b0011;
    for (int k = 1; k <= 12; k++) begin
      logic exp_c, exp_t;
      exp_c = ((k / 3) % 2) == 1;
      exp_t = (k % 3) == 0;
      step();
      n_tests++;
      if (bus.clk_div[1] !== exp_c) begin n_fail++; $display("FAIL n3_clk k=%0d got=%b exp=%b", k, bus.clk_div[1], exp_c); end
      n_tests++;
      if (bus.tick[1] !== exp_t) begin n_fail++; $display("FAIL n3_tick k=%0d got=%b exp=%b", k, bus.tick[1], exp_t); end
    end
  endtask

  task automatic test_reload();
    step();
    bus.div_load = 4'b0010; set_val(1, 5);
    step();
    bus.div_load = '0;
    n_tests++;
    if ({bus.pending[1], bus.clk_div[1], bus.tick[1]} !== 3'b100) begin
      n_fail++; $display("FAIL reload_wait got=%b exp=100", {bus.pending[1], bus.clk_div[1], bus.tick[1]});
    end
    step();
    n_tests++;
    if ({bus.pending[1], bus.clk_div[1], bus.tick[1]} !== 3'b011) begin
      n_fail++; $display("FAIL reload_boundary got=%b exp=011", {bus.pending[1], bus.clk_div[1], bus.tick[1]});
    end
    for (int j = 1; j <= 10; j++) begin
      logic exp_c, exp_t;
      exp_c = (j < 5) || (j == 10);
      exp_t = (j % 5) == 0;
      step();
      n_tests++;
      if ({bus.clk_div[1], bus.tick[1]} !== {exp_c, exp_t}) begin
        n_fail++; $display("FAIL reload_n5 j=%0d got=%b exp=%b", j, {bus.clk_div[1], bus.tick[1]}, {exp_c, exp_t});
      end
    end
  endtask

  task automatic test_freeze();
    bus.div_load = 4'b0100; set_val(2, 4);
    step();
    bus.div_load = '0;
    step();
    bus.en = 4'b0111;
    step();
    bus.en = 4'b0011;
    for (int j = 1; j <= 4; j++) begin
      step();
      n_tests++;
      if ({bus.clk_div[2], bus.tick[2]} !== 2'b00) begin
        n_fail++; $display("FAIL freeze_hold j=%0d got=%b exp=00", j, {bus.clk_div[2], bus.tick[2]});
      end
    end
    bus.en = 4'b0111;
    for (int j = 1; j <= 3; j++) begin
      logic [1:0] exp_v;
      exp_v = (j == 3) ? 2'b11 : 2'b00;
      step();
      n_tests++;
      if ({bus.clk_div[2], bus.tick[2]} !== exp_v) begin
        n_fail++; $display("FAIL freeze_resume j=%0d got=%b exp=%b", j, {bus.clk_div[2], bus.tick[2]}, exp_v);
      end
    end
  endtask

  task automatic test_off_and_sync();
    bus.div_load = 4'b0001; set_val(0, 0);
    step();
    bus.div_load = '0;
    step();
    for (int j = 1; j <= 20; j++) begin
      step();
      n_tests++;
      if ({bus.clk_div[0], bus.tick[0]} !== 2'b00) begin
        n_fail++; $display("FAIL off_ch0 j=%0d got=%b exp=00", j, {bus.clk_div[0], bus.tick[0]});
      end
    end
    bus.en = 4'b1011;
    for (int j = 0; j < 5; j++) step();
    bus.sync_clr = 1'b1; bus.div_load = 4'b1010; set_val(1, 3); set_val(3, 7);
    step();
    bus.sync_clr = 1'b0; bus.div_load = '0;
    n_tests++;
    if ({bus.clk_div[1], bus.clk_div[3], bus.tick, bus.pending} !== 10'b0) begin
      n_fail++; $display("FAIL sync_clr got=%b exp=0", {bus.clk_div[1], bus.clk_div[3], bus.tick, bus.pending});
    end
    for (int k = 1; k <= 7; k++) begin
      logic [3:0] exp_v;
      exp_v = {(k >= 3 && k < 6), (k == 3 || k == 6), (k == 7), (k == 7)};
      step();
      n_tests++;
      if ({bus.clk_div[1], bus.tick[1], bus.clk_div[3], bus.tick[3]} !== exp_v) begin
        n_fail++; $display("FAIL sync_realign k=%0d got=%b exp=%b", k,
                           {bus.clk_div[1], bus.tick[1], bus.clk_div[3], bus.tick[3]}, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    bus.div_load = 4'b0010; set_val(1, 2);
    step();
    bus.div_load = '0;
    n_tests++;
    if (bus.pending[1] !== 1'b1) begin n_fail++; $display("FAIL pre_rst_pending got=%b exp=1", bus.pending[1]); end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({bus.clk_div, bus.tick, bus.pending} !== 12'b0) begin
      n_fail++; $display("FAIL async_rst got=%b exp=0", {bus.clk_div, bus.tick, bus.pending});
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1; bus.en = 4'b1111;
    for (int k = 1; k <= 8; k++) begin
      logic [3:0] exp_c;
      exp_c = k[0] ? 4'b1111 : 4'b0000;
      step();
      n_tests++;
      if ({bus.clk_div, bus.tick} !== {exp_c, 4'b1111}) begin
        n_fail++; $display("FAIL post_rst_def k=%0d got=%b exp=%b", k, {bus.clk_div, bus.tick}, {exp_c, 4'b1111});
      end
    end
  endtask

  task automatic test_random_load();
    bus.en = 4'b1111;
    for (int c = 0; c < 300; c++) begin
      bus.sync_clr = ($urandom_range(0, 29) == 0);
      for (int i = 0; i < NUM_CH; i++) begin
        bus.div_load[i] = ($urandom_range(0, 7) == 0);
        set_val(i, $urandom_range(0, 6));
      end
      step();
      n_tests++;
      if (bus.clk_div !== exp_out()) begin n_fail++; $display("FAIL rand_load_clk c=%0d got=%b exp=%b", c, bus.clk_div, exp_out()); end
      n_tests++;
      if (bus.tick !== exp_tick()) begin n_fail++; $display("FAIL rand_load_tick c=%0d got=%b exp=%b", c, bus.tick, exp_tick()); end
      n_tests++;
      if (bus.pending !== exp_pend()) begin n_fail++; $display("FAIL rand_load_pend c=%0d got=%b exp=%b", c, bus.pending, exp_pend()); end
    end
  endtask

  task automatic test_random_en();
    bus.div_load = '0; bus.sync_clr = 1'b1; bus.en = 4'b1111;
    step();
    for (int c = 0; c < 300; c++) begin
      bus.sync_clr = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NUM_CH; i++) bus.en[i] = ($urandom_range(0, 3) != 0);
      step();
      n_tests++;
      if (bus.clk_div !== exp_out()) begin n_fail++; $display("FAIL rand_en_clk c=%0d got=%b exp=%b", c, bus.clk_div, exp_out()); end
      n_tests++;
      if (bus.tick !== exp_tick()) begin n_fail++; $display("FAIL rand_en_tick c=%0d got=%b exp=%b", c, bus.tick, exp_tick()); end
      n_tests++;
      if (bus.pending !== exp_pend()) begin n_fail++; $display("FAIL rand_en_pend c=%0d got=%b exp=%b", c, bus.pending, exp_pend()); end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_pkg_helper();
    test_div2();
    test_load_n3();
    test_reload();
    test_freeze();
    test_off_and_sync();
    test_async_reset();
    test_random_load();
    test_random_en();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
